// File: rtl/cell_plotter.sv
// cell_plotter: walks a CELL x CELL pixel window per board cell and drives the VGA write port
// with a clipped-corner black/white disk over green, counting cells per 64-cell board pass.
module cell_plotter #(
  parameter int CELL = 12,
  parameter int CUT  = 3,
  parameter int XMAX = 159,
  parameter int YMAX = 119
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic       start,
  input  logic [7:0] x_in,
  input  logic [6:0] y_in,
  input  logic [1:0] select,
  output logic [7:0] vga_x,
  output logic [6:0] vga_y,
  output logic [2:0] colour,
  output logic       plot,
  output logic       busy,
  output logic       done,
  output logic [5:0] cell_count,
  output logic       frame_done
);
  localparam int DW = $clog2(CELL);
  localparam logic [DW-1:0] LAST = DW'(CELL - 1);
  localparam logic [DW:0] CUT_W = (DW + 1)'(CUT);
  localparam logic [8:0] XLIM = 9'(XMAX);
  localparam logic [7:0] YLIM = 8'(YMAX);
  typedef enum logic [1:0] {IDLE, DRAW, DONE} state_t;
  state_t state;
  logic [DW-1:0] dx, dy, mx, my;
  logic [DW:0] md;
  logic [7:0] x_lat;
  logic [6:0] y_lat;
  logic [1:0] sel_lat;
  logic [8:0] px;
  logic [7:0] py;
  logic disk, in_view, row_end;
  logic [2:0] pix_colour;
  // distance to the nearest vertical and horizontal edge; their sum shapes the clipped corners
  assign mx = (dx < LAST - dx) ? dx : LAST - dx;
  assign my = (dy < LAST - dy) ? dy : LAST - dy;
  assign md = {1'b0, mx} + {1'b0, my};
  assign disk = md >= CUT_W;
  assign px = {1'b0, x_lat} + 9'(dx);
  assign py = {1'b0, y_lat} + 8'(dy);
  assign in_view = (px <= XLIM) && (py <= YLIM);
  assign row_end = dx == LAST;
  assign pix_colour = (sel_lat[1] && disk) ? {3{sel_lat[0]}} : 3'b010;
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state      <= IDLE;
      dx         <= '0;
      dy         <= '0;
      x_lat      <= '0;
      y_lat      <= '0;
      sel_lat    <= '0;
      vga_x      <= '0;
      vga_y      <= '0;
      colour     <= '0;
      plot       <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      cell_count <= '0;
      frame_done <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          plot       <= 1'b0;
          busy       <= 1'b0;
          done       <= 1'b0;
          frame_done <= 1'b0;
          if (start) begin
            state   <= DRAW;
            x_lat   <= x_in;
            y_lat   <= y_in;
            sel_lat <= select;
            dx      <= '0;
            dy      <= '0;
          end
        end
        DRAW: begin
          vga_x  <= px[7:0];
          vga_y  <= py[6:0];
          colour <= pix_colour;
          plot   <= in_view;
          busy   <= 1'b1;
          dx     <= row_end ? '0 : dx + 1'b1;
          dy     <= row_end ? dy + 1'b1 : dy;
          if (row_end && dy == LAST) begin
            state      <= DONE;
            cell_count <= cell_count + 1'b1;
          end
        end
        DONE: begin
          // the count only reads zero here when the 64th cell has just wrapped it
          state      <= IDLE;
          plot       <= 1'b0;
          busy       <= 1'b0;
          done       <= 1'b1;
          frame_done <= cell_count == 6'd0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_cell_plotter.sv
// tb_cell_plotter: directed bench for cell_plotter with hand-computed expectations.
module tb_cell_plotter;
  logic clock = 1'b0;
  logic resetn = 1'b0;
  logic start = 1'b0;
  logic [7:0] x_in = '0;
  logic [6:0] y_in = '0;
  logic [1:0] select = '0;
  logic [7:0] vga_x;
  logic [6:0] vga_y;
  logic [2:0] colour;
  logic plot, busy, done, frame_done;
  logic [5:0] cell_count;
  int checks = 0;
  int errors = 0;
  int px[144], py[144], pc[144], pp[144];
  int busy_t, busy_n, plot_n, done_in, fd_in, done_t, fd_t, cnt_t, plot_t, fd_total;

  cell_plotter dut (
    .clock(clock), .resetn(resetn), .start(start), .x_in(x_in), .y_in(y_in),
    .select(select), .vga_x(vga_x), .vga_y(vga_y), .colour(colour), .plot(plot),
    .busy(busy), .done(done), .cell_count(cell_count), .frame_done(frame_done)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic run_cell(input logic [7:0] x, input logic [6:0] y, input logic [1:0] s,
                          input bit hold, input bit mid_change);
    x_in = x;
    y_in = y;
    select = s;
    start = 1'b1;
    @(posedge clock);
    @(negedge clock);
    busy_t = int'(busy);
    if (!hold) start = 1'b0;
    busy_n = 0;
    plot_n = 0;
    done_in = 0;
    fd_in = 0;
    for (int k = 0; k < 144; k++) begin
      @(negedge clock);
      px[k] = int'(vga_x);
      py[k] = int'(vga_y);
      pc[k] = int'(colour);
      pp[k] = int'(plot);
      busy_n += int'(busy);
      plot_n += int'(plot);
      done_in += int'(done);
      fd_in += int'(frame_done);
      if (mid_change && k == 50) begin
        select = 2'd0;
        x_in = 8'd0;
        y_in = 7'd0;
      end
    end
    @(negedge clock);
    done_t = int'(done);
    fd_t = int'(frame_done);
    cnt_t = int'(cell_count);
    plot_t = int'(plot);
  endtask

  function automatic int count_colour(input int c);
    int n = 0;
    for (int k = 0; k < 144; k++) if (pc[k] == c) n++;
    return n;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    int viol;
    for (int i = 0; i < 6; i++) begin
      @(negedge clock);
      start = 1'($urandom);
      x_in = 8'($urandom);
      y_in = 7'($urandom);
      select = 2'($urandom);
      check("reset_outs", {vga_x, vga_y, colour, plot, busy, done, cell_count, frame_done}, 0);
    end
    start = 1'b0;
    @(negedge clock);
    resetn = 1'b1;
    repeat (3) @(negedge clock);
    check("idle_busy", busy, 0);
    check("idle_plot", plot, 0);

    run_cell(8'd9, 7'd9, 2'd3, 0, 0);
    check("w_busy_T", busy_t, 0);
    check("w_busy_n", busy_n, 144);
    check("w_plot_n", plot_n, 144);
    check("w_done_early", done_in, 0);
    check("w_done", done_t, 1);
    check("w_plot_done", plot_t, 0);
    check("w_x0", px[0], 9);
    check("w_y0", py[0], 9);
    check("w_c0", pc[0], 2);
    check("w_x78", px[78], 15);
    check("w_y78", py[78], 15);
    check("w_c78", pc[78], 7);
    check("w_x11", px[11], 20);
    check("w_c11", pc[11], 2);
    check("w_x3", px[3], 12);
    check("w_c3", pc[3], 7);
    check("w_white_n", count_colour(7), 120);
    check("w_cnt", cnt_t, 1);
    check("w_fd", fd_t, 0);

    run_cell(8'd30, 7'd40, 2'd1, 0, 0);
    check("e_green_n", count_colour(2), 144);
    check("e_cnt", cnt_t, 2);

    run_cell(8'd0, 7'd0, 2'd2, 0, 0);
    check("b_c78", pc[78], 0);
    check("b_c0", pc[0], 2);
    check("b_black_n", count_colour(0), 120);

    run_cell(8'd150, 7'd110, 2'd3, 0, 0);
    check("c_plot_n", plot_n, 100);
    check("c_done", done_t, 1);
    check("c_p9", pp[9], 1);
    check("c_p10", pp[10], 0);
    check("c_p120", pp[120], 0);
    viol = 0;
    for (int k = 0; k < 144; k++) if (pp[k] != 0 && (px[k] > 159 || py[k] > 119)) viol++;
    check("c_viol", viol, 0);
    check("c_cnt", cnt_t, 4);

    run_cell(8'd9, 7'd9, 2'd3, 1, 1);
    check("h_busy_n", busy_n, 144);
    check("h_done_early", done_in, 0);
    check("h_done", done_t, 1);
    check("h_c78", pc[78], 7);
    check("h_x78", px[78], 15);
    check("h_white_n", count_colour(7), 120);
    check("h_cnt", cnt_t, 5);
    run_cell(8'd20, 7'd20, 2'd2, 0, 0);
    check("h2_busy_T", busy_t, 0);
    check("h2_x0", px[0], 20);
    check("h2_busy_n", busy_n, 144);
    check("h2_cnt", cnt_t, 6);

    x_in = 8'd9;
    y_in = 7'd9;
    select = 2'd3;
    start = 1'b1;
    @(posedge clock);
    @(negedge clock);
    start = 1'b0;
    for (int k = 0; k <= 50; k++) @(negedge clock);
    check("r_plot_pre", plot, 1);
    resetn = 1'b0;
    #1;
    check("r_plot", plot, 0);
    check("r_busy", busy, 0);
    check("r_cnt", cell_count, 0);
    @(negedge clock);
    resetn = 1'b1;
    done_in = 0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clock);
      done_in += int'(done);
    end
    check("r_no_done", done_in, 0);
    check("r_cnt_after", cell_count, 0);

    fd_total = 0;
    for (int i = 0; i < 64; i++) begin
      run_cell(8'(i * 2), 7'(i), 2'(i % 4), 0, 0);
      fd_total += fd_in;
      if (i == 0) check("f_cnt1", cnt_t, 1);
      if (i == 62) check("f_cnt63", cnt_t, 63);
      check("f_fd", fd_t, (i == 63) ? 1 : 0);
    end
    check("f_cnt_wrap", cnt_t, 0);
    check("f_fd_stray", fd_total, 0);
    @(negedge clock);
    check("f_fd_pulse", frame_done, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
